// File: rtl/sys1_pause_pkg.sv
// sys1_pause_pkg: shared types and constants for the System 1 pause arbiter
package sys1_pause_pkg;

    typedef enum logic [2:0] {IDLE, SYNC, QUIESCE, GRANT, RELEASE} hs_state_t;

    localparam logic [31:0] DIM_CYCLES_48M = 32'h1C9C3800;
    localparam int          SETTLE_DEFAULT = 16;

endpackage

// File: rtl/pause_dim_timer.sv
// pause_dim_timer: saturating run-time counter that requests video dim after DIM_CYCLES
module pause_dim_timer
    import sys1_pause_pkg::*;
#(
    parameter logic [31:0] DIM_CYCLES = DIM_CYCLES_48M
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic run,
    output logic dim
);

    logic [31:0] cnt;

    // count while running, clear when stopped, hold at the threshold
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            dim <= 1'b0;
        end else begin
            cnt <= !run ? '0 : (cnt >= DIM_CYCLES ? cnt : cnt + 32'd1);
            dim <= cnt >= DIM_CYCLES;
        end
    end

endmodule

// File: rtl/pause_arbiter.sv
// pause_arbiter: merges user, OSD and high-score halt requests into the core PAUSE_N
module pause_arbiter
    import sys1_pause_pkg::*;
#(
    parameter logic [31:0] DIM_CYCLES = DIM_CYCLES_48M,
    parameter int          SETTLE     = SETTLE_DEFAULT,
    parameter int          CW         = 5
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic btn_pause,
    input  logic osd_open,
    input  logic osd_pause_en,
    input  logic vblank,
    input  logic hs_req,
    output logic hs_gnt,
    output logic pause_n,
    output logic user_paused,
    output logic dim
);

    hs_state_t     state, state_nx;
    logic [CW-1:0] cnt;
    logic          btn_prev;
    logic          halt_src;

    // the FSM holds the core halted in every state past the vblank wait
    assign halt_src = user_paused | (osd_open & osd_pause_en) | (state != IDLE && state != SYNC);

    // high-score handshake next-state; an already-halted core skips the vblank wait
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = !hs_req ? IDLE : (!pause_n ? QUIESCE : SYNC);
            SYNC:    state_nx = !hs_req ? IDLE : (vblank ? QUIESCE : SYNC);
            QUIESCE: state_nx = !hs_req ? IDLE : (cnt == CW'(SETTLE - 1) ? GRANT : QUIESCE);
            GRANT:   state_nx = hs_req ? GRANT : RELEASE;
            default: state_nx = IDLE;
        endcase
    end

    // toggle, settle counter, FSM register and registered outputs
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            btn_prev    <= 1'b0;
            user_paused <= 1'b0;
            state       <= IDLE;
            cnt         <= '0;
            hs_gnt      <= 1'b0;
            pause_n     <= 1'b1;
        end else begin
            btn_prev    <= btn_pause;
            user_paused <= user_paused ^ (btn_pause & ~btn_prev);
            state       <= state_nx;
            cnt         <= (state == QUIESCE) ? cnt + 1'b1 : '0;
            hs_gnt      <= state_nx == GRANT;
            pause_n     <= ~halt_src;
        end
    end

    pause_dim_timer #(.DIM_CYCLES(DIM_CYCLES)) u_dim (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .run     (user_paused),
        .dim     (dim)
    );

endmodule

// File: tb/tb_pause_arbiter.sv
// tb_pause_arbiter: directed checks of toggle, handshake timing, dim timer and async reset
module tb_pause_arbiter;

    logic clk_sys = 1'b0;
    logic reset_n, btn_pause, osd_open, osd_pause_en, vblank, hs_req;
    logic hs_gnt, pause_n, user_paused, dim;
    int   checks = 0;
    int   errors = 0;

    always #5 clk_sys = ~clk_sys;

    pause_arbiter #(.DIM_CYCLES(32'd100), .SETTLE(16), .CW(5)) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .btn_pause    (btn_pause),
        .osd_open     (osd_open),
        .osd_pause_en (osd_pause_en),
        .vblank       (vblank),
        .hs_req       (hs_req),
        .hs_gnt       (hs_gnt),
        .pause_n      (pause_n),
        .user_paused  (user_paused),
        .dim          (dim)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic press();
        btn_pause = 1'b1;
        tick();
        btn_pause = 1'b0;
        tick();
    endtask

    initial begin
        int   n;
        logic bad;
        reset_n = 1'b0; btn_pause = 1'b0; osd_open = 1'b0; osd_pause_en = 1'b0;
        vblank = 1'b0; hs_req = 1'b0;
        tick(2);
        chk("rst_pause_n", pause_n, 1);
        chk("rst_hs_gnt", hs_gnt, 0);
        chk("rst_user_paused", user_paused, 0);
        chk("rst_dim", dim, 0);
        reset_n = 1'b1;
        tick();

        btn_pause = 1'b1;
        tick();
        chk("toggle_up", user_paused, 1);
        chk("toggle_pause_lag", pause_n, 1);
        tick();
        chk("toggle_pause_n", pause_n, 0);
        bad = 1'b0;
        for (int i = 0; i < 48; i++) begin
            tick();
            bad |= (user_paused !== 1'b1);
        end
        chk("held_no_retoggle", bad, 0);
        btn_pause = 1'b0;
        tick();
        btn_pause = 1'b1;
        tick();
        chk("toggle_down", user_paused, 0);
        tick();
        chk("unpause_pause_n", pause_n, 1);
        btn_pause = 1'b0;
        tick();
        chk("short_pause_no_dim", dim, 0);

        hs_req = 1'b1;
        tick(100);
        chk("sync_wait_pause_n", pause_n, 1);
        chk("sync_wait_gnt", hs_gnt, 0);
        vblank = 1'b1;
        tick();
        chk("vb_plus1_pause_n", pause_n, 1);
        tick();
        chk("vb_plus2_pause_n", pause_n, 0);
        vblank = 1'b0;
        tick(14);
        chk("vb_plus16_gnt", hs_gnt, 0);
        tick();
        chk("vb_plus17_gnt", hs_gnt, 1);
        hs_req = 1'b0;
        tick();
        chk("drop_gnt", hs_gnt, 0);
        chk("release_hold", pause_n, 0);
        tick();
        chk("release_hold2", pause_n, 0);
        tick();
        chk("release_pause_n", pause_n, 1);

        press();
        chk("user_pause_again", pause_n, 0);
        hs_req = 1'b1;
        tick(16);
        chk("skip_sync_gnt16", hs_gnt, 0);
        tick();
        chk("skip_sync_gnt17", hs_gnt, 1);
        btn_pause = 1'b1;
        tick();
        btn_pause = 1'b0;
        chk("unpause_in_grant_up", user_paused, 0);
        tick(2);
        chk("unpause_in_grant_pause_n", pause_n, 0);
        press();
        chk("repause", user_paused, 1);
        hs_req = 1'b0;
        tick();
        chk("user_release_gnt", hs_gnt, 0);
        tick(3);
        chk("user_release_pause_n", pause_n, 0);
        press();
        tick();
        chk("user_unpause", pause_n, 1);

        hs_req = 1'b1;
        vblank = 1'b1;
        tick(2);
        vblank = 1'b0;
        tick(5);
        hs_req = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            bad |= (hs_gnt !== 1'b0);
        end
        chk("abort_no_gnt", bad, 0);
        chk("abort_pause_n", pause_n, 1);

        btn_pause = 1'b1;
        n = 0;
        tick();
        btn_pause = 1'b0;
        while (dim !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("dim_latency_ok", (n + 1 >= 101 && n + 1 <= 102) ? 1 : 0, 1);
        bad = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            bad |= (dim !== 1'b1);
        end
        chk("dim_holds", bad, 0);
        press();
        tick();
        chk("undim", dim, 0);
        osd_open = 1'b1;
        osd_pause_en = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 500; i++) begin
            tick();
            bad |= (dim !== 1'b0);
        end
        chk("osd_no_dim", bad, 0);
        chk("osd_pause_n", pause_n, 0);
        osd_pause_en = 1'b0;
        tick(2);
        chk("osd_no_en_pause_n", pause_n, 1);
        osd_open = 1'b0;

        press();
        hs_req = 1'b1;
        tick(17);
        chk("pre_reset_gnt", hs_gnt, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_gnt", hs_gnt, 0);
        chk("async_pause_n", pause_n, 1);
        chk("async_user", user_paused, 0);
        hs_req = 1'b0;
        tick(2);
        reset_n = 1'b1;
        hs_req = 1'b1;
        vblank = 1'b0;
        tick(5);
        chk("post_reset_idle_pause_n", pause_n, 1);
        chk("post_reset_idle_gnt", hs_gnt, 0);
        hs_req = 1'b0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
